nor_flash_bank: RTL and testbench

NOR_FLASH_BANK -- requirements
Module: nor_flash_bank

---
 rtl/nor_flash_pkg.sv | 18 +
 rtl/nor_flash_array.sv | 33 +++
 rtl/nor_flash_bank.sv | 147 ++++++++++++++
 tb/tb_nor_flash_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_flash_pkg.sv
// Shared encodings for the NOR flash bank: command opcodes and the
// controller state type. Imported by the bank top level.
package nor_flash_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_PROG  = 2'b01,
        OP_ERASE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PROG  = 2'b01,
        ST_ERASE = 2'b10
    } state_e;

endpackage

// File: rtl/nor_flash_array.sv
// Storage for the flash bank: synchronous 1R/1W RAM, DATA_W x 2^ADDR_W.
// Ports: clk_i; rd_en_i/rd_addr_i -> rd_data_o (registered, one cycle);
//        wr_en_i/wr_addr_i/wr_data_i (written on the rising edge).
module nor_flash_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    // Words are kept inverted so a zero-initialised RAM (and the zero
    // read register) reads back as an erased, all-ones array.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= ~wr_data_i;
        end
        if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = ~rd_q;

endmodule

// File: rtl/nor_flash_bank.sv
// NOR flash bank controller: read, bit-clearing program, sector erase.
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready handshake
//        with cmd_op, address, data_in; data_out/rd_valid read return;
//        busy while programming/erasing; err one-cycle error pulse.
module nor_flash_bank
    import nor_flash_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int SECTOR_W    = 4,
    parameter int PROG_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int PC_W  = $clog2(PROG_CYCLES + 1);
    localparam int CNT_W = (SECTOR_W + 1 > PC_W) ? SECTOR_W + 1 : PC_W;
    localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'((1 << SECTOR_W) - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK =
        ADDR_W'((64'd1 << SECTOR_W) - 64'd1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rd_valid_q;
    logic              err_q;

    logic              accept;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              prog_err;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;

    // A program also fetches the old word at acceptance; it is held in
    // the array read register for the commit at the end of PROG.
    assign rd_en = accept & ((cmd_op == OP_READ) | (cmd_op == OP_PROG));

    assign prog_err = |(data_q & ~rd_data);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr_q;
        wr_data = rd_data & data_q;
        if (state_q == ST_PROG) begin
            wr_en = (cnt_q == PROG_LAST);
        end else if (state_q == ST_ERASE) begin
            wr_en   = 1'b1;
            wr_addr = addr_q | (ADDR_W'(cnt_q) & OFF_MASK);
            wr_data = '1;
        end
    end

    nor_flash_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i     (clk),
        .rd_en_i   (rd_en),
        .rd_addr_i (address),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_READ: begin
                                rd_valid_q <= 1'b1;
                            end
                            OP_PROG: begin
                                addr_q  <= address;
                                data_q  <= data_in;
                                cnt_q   <= '0;
                                state_q <= ST_PROG;
                            end
                            OP_ERASE: begin
                                addr_q  <= address & ~OFF_MASK;
                                cnt_q   <= '0;
                                state_q <= ST_ERASE;
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_PROG: begin
                    if (cnt_q == PROG_LAST) begin
                        err_q   <= prog_err;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ERASE: begin
                    if (cnt_q == ERASE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_valid = rd_valid_q;
    assign data_out = rd_valid_q ? rd_data : '0;
    assign err      = err_q;

endmodule

// File: tb/tb_nor_flash_bank.sv
// Self-checking bench for nor_flash_bank (default parameters).
// Cycle model of the bank plus directed literal checks.
module tb_nor_flash_bank;

    localparam int PROG_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       cmd_ready;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       busy;
    logic       err;

    nor_flash_bank dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: flash words, remaining busy cycles, and the
    // pending program that lands when the busy time runs out.
    logic [7:0] mem [256];
    int         bl = 0;
    bit         pend = 1'b0;
    logic [7:0] pa = 8'h00;
    logic [7:0] pd = 8'h00;
    logic       exp_rv = 1'b0;
    logic       exp_err = 1'b0;
    logic [7:0] exp_dout = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bl       <= 0;
            pend     <= 1'b0;
            exp_rv   <= 1'b0;
            exp_err  <= 1'b0;
            exp_dout <= 8'h00;
        end else begin
            exp_rv   <= 1'b0;
            exp_err  <= 1'b0;
            exp_dout <= 8'h00;
            if (bl > 0) begin
                bl <= bl - 1;
                if (bl == 1 && pend) begin
                    mem[pa] <= mem[pa] & pd;
                    exp_err <= |(pd & ~mem[pa]);
                    pend    <= 1'b0;
                end
            end else if (cmd_valid) begin
                case (cmd_op)
                    2'b00: begin
                        exp_rv   <= 1'b1;
                        exp_dout <= mem[address];
                    end
                    2'b01: begin
                        bl   <= PROG_CYCLES;
                        pend <= 1'b1;
                        pa   <= address;
                        pd   <= data_in;
                    end
                    2'b10: begin
                        bl <= 16;
                        for (int k = 0; k < 16; k++) begin
                            mem[{address[7:4], 4'(k)}] <= 8'hFF;
                        end
                    end
                    default: begin
                        exp_err <= 1'b1;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("m_ready", {31'd0, cmd_ready}, {31'd0, bl == 0});
            chk("m_busy", {31'd0, busy}, {31'd0, bl != 0});
            chk("m_rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
            chk("m_data_out", {24'd0, data_out},
                {24'd0, exp_rv ? exp_dout : 8'h00});
            chk("m_err", {31'd0, err}, {31'd0, exp_err});
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        address   = a;
        data_in   = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Counts busy cycles; returns at the first idle negedge.
    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            chk("idle_timeout", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] e);
        issue(2'b00, a, 8'h00);
        @(negedge clk);
        chk($sformatf("rd_valid_%02h", a), {31'd0, rd_valid}, 32'd1);
        chk($sformatf("rd_data_%02h", a), {24'd0, data_out}, {24'd0, e});
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'hFF;
        end

        #2;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        // Back-to-back reads of the erased array
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        address   = 8'h00;
        @(posedge clk);
        #1;
        address = 8'hFF;
        @(negedge clk);
        chk("b2b_rv0", {31'd0, rd_valid}, 32'd1);
        chk("b2b_d0", {24'd0, data_out}, 32'hFF);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rv1", {31'd0, rd_valid}, 32'd1);
        chk("b2b_d1", {24'd0, data_out}, 32'hFF);
        @(negedge clk);
        chk("b2b_rv_end", {31'd0, rd_valid}, 32'd0);
        chk("b2b_d_end", {24'd0, data_out}, 32'd0);

        // Program 0x10 <- 0xA5 on an erased word
        issue(2'b01, 8'h10, 8'hA5);
        wait_idle(n);
        chk("prog1_busy", n, 32'd4);
        chk("prog1_err", {31'd0, err}, 32'd0);
        do_read(8'h10, 8'hA5);

        // Program 0x10 <- 0x5A tries to set bits
        issue(2'b01, 8'h10, 8'h5A);
        wait_idle(n);
        chk("prog2_busy", n, 32'd4);
        chk("prog2_err", {31'd0, err}, 32'd1);
        @(negedge clk);
        chk("prog2_err_pulse", {31'd0, err}, 32'd0);
        do_read(8'h10, 8'h00);

        // Reset during third PROG cycle discards the program
        issue(2'b01, 8'h20, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rv", {31'd0, rd_valid}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_dout", {24'd0, data_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_read(8'h20, 8'hFF);

        // Reserved op
        issue(2'b11, 8'h44, 8'h00);
        @(negedge clk);
        chk("rsvd_err", {31'd0, err}, 32'd1);
        chk("rsvd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        chk("rsvd_err_pulse", {31'd0, err}, 32'd0);

        // Read presented while busy is ignored
        issue(2'b01, 8'h30, 8'hF0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        address   = 8'h00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("busy_read_rv", {31'd0, rd_valid}, 32'd0);
        wait_idle(n);
        chk("busy_read_err", {31'd0, err}, 32'd0);
        do_read(8'h30, 8'hF0);

        // Sector erase at 0x13 with neighbours programmed
        issue(2'b01, 8'h0F, 8'h12);
        wait_idle(n);
        issue(2'b01, 8'h20, 8'h34);
        wait_idle(n);
        issue(2'b01, 8'h1C, 8'h00);
        wait_idle(n);
        do_read(8'h1C, 8'h00);
        issue(2'b10, 8'h13, 8'h00);
        wait_idle(n);
        chk("erase_busy", n, 32'd16);
        for (int a = 8'h10; a <= 8'h1F; a++) begin
            do_read(8'(a), 8'hFF);
        end
        do_read(8'h0F, 8'h12);
        do_read(8'h20, 8'h34);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
